// File: rtl/detect_payload_capture.sv
// Payload capture stage behind the 111000000111 sequence detector: after each detect pulse,
// de-serialises the next PAYLOAD_W bits (LSB first) onto a valid/ready output.
module detect_payload_capture #(
    parameter int unsigned PAYLOAD_W = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_i,
    input  logic                 det_i,
    input  logic                 ready_i,
    output logic [PAYLOAD_W-1:0] data_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic [CNT_W-1:0]     frame_cnt_o
);

    localparam int unsigned BitCntW = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(PAYLOAD_W - 1);

    typedef enum logic {StHunt, StCapture} state_t;

    state_t               state, state_next;
    logic [BitCntW-1:0]   bit_cnt, bit_cnt_next;
    logic [PAYLOAD_W-1:0] payload, payload_next;
    logic                 complete;

    logic [PAYLOAD_W-1:0] data_next;
    logic                 valid_next;
    logic                 overflow_next;
    logic [CNT_W-1:0]     frame_cnt_next;

    // Capture FSM; det_i is deliberately ignored outside HUNT since the payload may hold the sync word.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        payload_next = payload;
        complete     = 1'b0;
        unique case (state)
            StHunt: begin
                if (det_i) begin
                    payload_next    = '0;
                    payload_next[0] = x_i;
                    if (PAYLOAD_W == 1) begin
                        complete = 1'b1;
                    end else begin
                        state_next   = StCapture;
                        bit_cnt_next = BitCntW'(1);
                    end
                end
            end
            StCapture: begin
                for (int i = 0; i < PAYLOAD_W; i++) begin
                    if (BitCntW'(i) == bit_cnt) begin
                        payload_next[i] = x_i;
                    end
                end
                if (bit_cnt == LastBit) begin
                    complete     = 1'b1;
                    state_next   = StHunt;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt + BitCntW'(1);
                end
            end
            default: state_next = StHunt;
        endcase
    end

    // Output register: a completed frame loads if the slot is free or being emptied this edge.
    always_comb begin
        data_next      = data_o;
        valid_next     = valid_o;
        overflow_next  = 1'b0;
        frame_cnt_next = frame_cnt_o;
        if (valid_o && ready_i) begin
            valid_next = 1'b0;
        end
        if (complete) begin
            if (!valid_o || ready_i) begin
                data_next      = payload_next;
                valid_next     = 1'b1;
                frame_cnt_next = frame_cnt_o + CNT_W'(1);
            end else begin
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StHunt;
            bit_cnt     <= '0;
            payload     <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            overflow_o  <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            payload     <= payload_next;
            data_o      <= data_next;
            valid_o     <= valid_next;
            overflow_o  <= overflow_next;
            frame_cnt_o <= frame_cnt_next;
        end
    end

    assign busy_o = (state == StCapture);

endmodule

// File: tb/tb_detect_payload_capture.sv
// Scoreboard bench for detect_payload_capture: directed frames plus random traffic against a
// queue-based reference model of capture, delivery, drop and counter wrap.
module tb_detect_payload_capture;

    localparam int unsigned PW = 8;
    localparam int unsigned CW = 2;

    logic          clk;
    logic          rst;
    logic          x_i;
    logic          det_i;
    logic          ready_i;
    logic [PW-1:0] data_o;
    logic          valid_o;
    logic          busy_o;
    logic          overflow_o;
    logic [CW-1:0] frame_cnt_o;

    detect_payload_capture #(
        .PAYLOAD_W(PW),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_i        (x_i),
        .det_i      (det_i),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o),
        .frame_cnt_o(frame_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bits collected in a queue, output slot as plain variables.
    bit              capturing;
    bit              cap[$];
    bit              m_valid;
    bit [PW-1:0]     m_data;
    int              m_cnt;
    bit              m_ovf;
    logic [PW+CW-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        capturing = 0;
        cap.delete();
        m_valid = 0;
        m_data = '0;
        m_cnt = 0;
        m_ovf = 0;
        sb.delete();
    endtask

    task automatic model_step(input bit x, input bit det, input bit rdy);
        bit          done;
        bit [PW-1:0] word;
        done = 0;
        word = '0;
        m_ovf = 0;
        if (!capturing) begin
            if (det) begin
                cap.delete();
                cap.push_back(x);
                capturing = 1;
            end
        end else begin
            cap.push_back(x);
        end
        if (capturing && cap.size() == PW) begin
            done = 1;
            capturing = 0;
            for (int i = 0; i < PW; i++) word = word + (PW'(cap[i]) << i);
        end
        if (m_valid && rdy) m_valid = 0;
        if (done) begin
            if (!m_valid) begin
                m_valid = 1;
                m_data = word;
                m_cnt = (m_cnt + 1) % (1 << CW);
                sb.push_back({word, CW'(m_cnt)});
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    // Inputs change 2 time units after the rising edge; the model advances at the edge.
    task automatic drive(input bit x, input bit det, input bit rdy);
        x_i = x;
        det_i = det;
        ready_i = rdy;
        @(posedge clk);
        if (!rst) model_step(x, det, rdy);
        #2;
    endtask

    task automatic send_frame(input logic [PW-1:0] w, input logic [PW-1:0] dmask,
                              input bit rdy_body, input bit rdy_last);
        logic [PW-1:0] wv;
        wv = w;
        drive(wv[0], 1'b1, rdy_body);
        for (int i = 1; i < PW; i++) drive(wv[i], dmask[i], (i == PW - 1) ? rdy_last : rdy_body);
    endtask

    // Monitor: mid-cycle compare of status outputs, and scoreboard pop on every transfer.
    always @(negedge clk) begin
        logic [PW+CW-1:0] e;
        chk("valid", valid_o, m_valid);
        chk("busy", busy_o, capturing);
        chk("overflow", overflow_o, m_ovf);
        chk("frame_cnt", frame_cnt_o, m_cnt);
        if (!rst && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 32'(data_o), 32'hdead);
            end else begin
                e = sb.pop_front();
                chk("xfer_data", data_o, e[PW+CW-1:CW]);
                chk("xfer_cnt", frame_cnt_o, e[CW-1:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        x_i = 1'b0;
        det_i = 1'b0;
        ready_i = 1'b0;
        model_reset();
        #1;
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_cnt", frame_cnt_o, 0);
        #11;
        rst = 1'b0;

        // Basic frame
        send_frame(8'h4D, 8'h00, 1'b1, 1'b1);
        chk("basic_data", data_o, 8'h4D);
        chk("basic_valid", valid_o, 1);
        chk("basic_cnt", frame_cnt_o, 1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);

        // Back-pressure: second frame dropped
        send_frame(8'hA5, 8'h00, 1'b0, 1'b0);
        send_frame(8'h3C, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("held_data", data_o, 8'hA5);
        chk("held_cnt", frame_cnt_o, 2);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        chk("drained_valid", valid_o, 0);

        // Simultaneous accept and load
        send_frame(8'h11, 8'h00, 1'b1, 1'b1);
        send_frame(8'h3C, 8'h00, 1'b0, 1'b1);
        chk("simul_data", data_o, 8'h3C);
        chk("simul_valid", valid_o, 1);
        drive(1'b0, 1'b0, 1'b1);

        // det inside payload, then back-to-back frame
        send_frame(8'hE7, 8'h88, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        send_frame(8'h96, 8'hFF, 1'b1, 1'b1);
        send_frame(8'h5A, 8'h00, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);

        // Reset mid-capture
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_data", data_o, 0);
        chk("arst_valid", valid_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_ovf", overflow_o, 0);
        chk("arst_cnt", frame_cnt_o, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'($urandom), 1'b0, 1'b1);

        // Counter wrap: 1,2,3,0,1 via scoreboard entries
        for (int f = 0; f < 5; f++) send_frame(PW'($urandom), PW'($urandom), 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) drive(1'($urandom), ($urandom % 5) == 0, ($urandom % 3) != 0);

        // Drain and confirm nothing is left undelivered
        for (int i = 0; i < PW + 4; i++) drive(1'b0, 1'b0, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
